// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//
// Multicycle main controller. Steps the shared datapath (PC, IR, register
// file, memory, ALU) through one instruction at a time and is the only source
// of ALU operation selects.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset (returns to FETCH)
//   opcode      IR[31:26]
//   funct       IR[5:0]
//   zero        ALU zero flag
//   pc_en       PC load enable, pc_write | (branch_eq & zero) | (branch_ne & ~zero)
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   mem_write   memory write strobe
//   ir_write    instruction register load
//   reg_write   register file write
//   reg_dst     write register: 0 = rt, 1 = rd
//   mem_to_reg  write data: 0 = ALUOut, 1 = MDR
//   alu_src_a   00 = PC, 01 = A, 10 = zero-extended shamt
//   alu_src_b   00 = B, 01 = PC_INC, 10 = ext(imm), 11 = signext(imm) << 2
//   ext_sel     immediate extension: 0 = sign, 1 = zero
//   pc_src      00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_sel     ALU op select
//   illegal     one-cycle pulse in DECODE for an unsupported opcode/funct
//   state_o     current state, for debug
// -----------------------------------------------------------------------------
module mc_control_fsm #(
  parameter int unsigned PC_INC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sel,
  output logic [1:0] pc_src,
  output logic [3:0] alu_sel,
  output logic       illegal,
  output logic [3:0] state_o
);

  // The datapath hard-wires the alu_src_b = 01 constant.
  if (PC_INC != 4) begin : g_pc_inc_check
    $error("mc_control_fsm: PC_INC must match the datapath constant 4");
  end

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BRANCH   = 4'd8,
    IMM_EX   = 4'd9,
    IMM_WB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0000;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRA = 6'b000011;

  state_t state;
  state_t nxt;

  // Registered copies of the per-state outputs
  logic       iord_r;
  logic       mem_write_r;
  logic       ir_write_r;
  logic       reg_write_r;
  logic       reg_dst_r;
  logic       mem_to_reg_r;
  logic [1:0] alu_src_a_r;
  logic [1:0] alu_src_b_r;
  logic       ext_sel_r;
  logic [1:0] pc_src_r;
  logic [3:0] alu_sel_r;
  logic       pc_write_r;
  logic       branch_eq_r;
  logic       branch_ne_r;

  // Instruction decode
  logic       funct_legal;
  logic       funct_shift;
  logic [3:0] rtype_alu;
  logic       op_legal;
  logic [3:0] imm_alu;
  logic       imm_zext;

  always_comb begin
    funct_legal = 1'b1;
    funct_shift = 1'b0;
    rtype_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  rtype_alu = ALU_ADD;
      FN_SUB:  rtype_alu = ALU_SUB;
      FN_AND:  rtype_alu = ALU_AND;
      FN_OR:   rtype_alu = ALU_OR;
      FN_XOR:  rtype_alu = ALU_XOR;
      FN_SLL: begin
        rtype_alu   = ALU_SLL;
        funct_shift = 1'b1;
      end
      FN_SRA: begin
        rtype_alu   = ALU_SRA;
        funct_shift = 1'b1;
      end
      default: funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_alu  = ALU_ADD;
    imm_zext = 1'b0;
    case (opcode)
      OP_ANDI: begin
        imm_alu  = ALU_AND;
        imm_zext = 1'b1;
      end
      OP_ORI: begin
        imm_alu  = ALU_OR;
        imm_zext = 1'b1;
      end
      default: begin
        imm_alu  = ALU_ADD;
        imm_zext = 1'b0;
      end
    endcase
  end

  always_comb begin
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_legal = 1'b1;
      OP_RTYPE:                       op_legal = funct_legal;
      default:                        op_legal = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW:            nxt = MEMADR;
          OP_RTYPE:                nxt = funct_legal ? RTYPE_EX : FETCH;
          OP_BEQ, OP_BNE:          nxt = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: nxt = IMM_EX;
          OP_J:                    nxt = JUMP;
          default:                 nxt = FETCH;
        endcase
      end
      MEMADR:   nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:    nxt = MEMWB;
      MEMWB:    nxt = FETCH;
      MEMWR:    nxt = FETCH;
      RTYPE_EX: nxt = RTYPE_WB;
      RTYPE_WB: nxt = FETCH;
      BRANCH:   nxt = FETCH;
      IMM_EX:   nxt = IMM_WB;
      IMM_WB:   nxt = FETCH;
      JUMP:     nxt = FETCH;
      default:  nxt = FETCH;
    endcase
  end

  // State register with outputs registered from the next state, so each
  // output register always holds the value belonging to the current state.
  // The reset values are therefore the FETCH outputs; write strobes are
  // separately masked while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      iord_r       <= 1'b0;
      mem_write_r  <= 1'b0;
      ir_write_r   <= 1'b1;
      reg_write_r  <= 1'b0;
      reg_dst_r    <= 1'b0;
      mem_to_reg_r <= 1'b0;
      alu_src_a_r  <= 2'b00;
      alu_src_b_r  <= 2'b01;
      ext_sel_r    <= 1'b0;
      pc_src_r     <= 2'b00;
      alu_sel_r    <= ALU_ADD;
      pc_write_r   <= 1'b1;
      branch_eq_r  <= 1'b0;
      branch_ne_r  <= 1'b0;
    end else begin
      state        <= nxt;
      iord_r       <= 1'b0;
      mem_write_r  <= 1'b0;
      ir_write_r   <= 1'b0;
      reg_write_r  <= 1'b0;
      reg_dst_r    <= 1'b0;
      mem_to_reg_r <= 1'b0;
      alu_src_a_r  <= 2'b00;
      alu_src_b_r  <= 2'b00;
      ext_sel_r    <= 1'b0;
      pc_src_r     <= 2'b00;
      alu_sel_r    <= ALU_ADD;
      pc_write_r   <= 1'b0;
      branch_eq_r  <= 1'b0;
      branch_ne_r  <= 1'b0;
      case (nxt)
        FETCH: begin
          ir_write_r  <= 1'b1;
          alu_src_b_r <= 2'b01;
          pc_write_r  <= 1'b1;
        end
        DECODE: begin
          alu_src_b_r <= 2'b11;
        end
        MEMADR: begin
          alu_src_a_r <= 2'b01;
          alu_src_b_r <= 2'b10;
        end
        MEMRD: begin
          iord_r <= 1'b1;
        end
        MEMWB: begin
          reg_write_r  <= 1'b1;
          mem_to_reg_r <= 1'b1;
        end
        MEMWR: begin
          iord_r      <= 1'b1;
          mem_write_r <= 1'b1;
        end
        RTYPE_EX: begin
          alu_src_a_r <= funct_shift ? 2'b10 : 2'b01;
          alu_sel_r   <= rtype_alu;
        end
        RTYPE_WB: begin
          reg_write_r <= 1'b1;
          reg_dst_r   <= 1'b1;
        end
        BRANCH: begin
          alu_src_a_r <= 2'b01;
          alu_sel_r   <= ALU_SUB;
          pc_src_r    <= 2'b01;
          branch_eq_r <= (opcode == OP_BEQ);
          branch_ne_r <= (opcode == OP_BNE);
        end
        IMM_EX: begin
          alu_src_a_r <= 2'b01;
          alu_src_b_r <= 2'b10;
          alu_sel_r   <= imm_alu;
          ext_sel_r   <= imm_zext;
        end
        IMM_WB: begin
          reg_write_r <= 1'b1;
        end
        JUMP: begin
          pc_src_r   <= 2'b10;
          pc_write_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes are suppressed during reset and in any unused state encoding.
  logic run;
  assign run = ~reset & (state <= JUMP);

  assign pc_en      = run & (pc_write_r | (branch_eq_r & zero) | (branch_ne_r & ~zero));
  assign mem_write  = run & mem_write_r;
  assign ir_write   = run & ir_write_r;
  assign reg_write  = run & reg_write_r;
  assign iord       = iord_r;
  assign reg_dst    = reg_dst_r;
  assign mem_to_reg = mem_to_reg_r;
  assign alu_src_a  = alu_src_a_r;
  assign alu_src_b  = alu_src_b_r;
  assign ext_sel    = ext_sel_r;
  assign pc_src     = pc_src_r;
  assign alu_sel    = alu_sel_r;
  assign illegal    = ~reset & (state == DECODE) & ~op_legal;
  assign state_o    = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//
// Self-checking bench for mc_control_fsm. A reference model turns each
// instruction into its list of steps and the expected outputs of each step,
// then compares the DUT cycle by cycle.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic       ext_sel, illegal;
  logic [3:0] alu_sel, state_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  mc_control_fsm #(.PC_INC(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_en(pc_en), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sel(ext_sel),
    .pc_src(pc_src), .alu_sel(alu_sel), .illegal(illegal), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef enum {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_REX, S_RWB, S_BRANCH, S_IEX, S_IWB, S_JUMP
  } step_t;

  logic [18:0] obs;
  logic [4:0]  strobes;
  assign obs = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_sel, pc_src, alu_sel, illegal};
  assign strobes = {pc_en, mem_write, ir_write, reg_write, illegal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ALU code for a legal R-type funct, or -1 when the funct is unsupported.
  function automatic int r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 2;
      6'b100010: return 0;
      6'b100100: return 8;
      6'b100101: return 9;
      6'b100110: return 10;
      6'b000000: return 3;
      6'b000011: return 7;
      default:   return -1;
    endcase
  endfunction

  function automatic logic [18:0] exp_out(input step_t s, input logic [5:0] opc,
                                          input logic [5:0] fn, input logic z);
    logic pe, io, mw, irw, rw, rd, m2r, es, ill;
    logic [1:0] a, b, ps;
    logic [3:0] op;
    pe = 0; io = 0; mw = 0; irw = 0; rw = 0; rd = 0; m2r = 0; es = 0; ill = 0;
    a = 0; b = 0; ps = 0; op = 4'b0010;
    case (s)
      S_FETCH:  begin irw = 1; b = 2'b01; pe = 1; end
      S_DECODE: begin
        b = 2'b11;
        ill = !(opc inside {6'b100011, 6'b101011, 6'b000100, 6'b000101,
                            6'b001000, 6'b001100, 6'b001101, 6'b000010}) &&
              !(opc == 6'b000000 && r_alu(fn) >= 0);
      end
      S_MEMADR: begin a = 2'b01; b = 2'b10; end
      S_MEMRD:  io = 1;
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin io = 1; mw = 1; end
      S_REX:    begin a = (fn == 6'b000000 || fn == 6'b000011) ? 2'b10 : 2'b01; op = 4'(r_alu(fn)); end
      S_RWB:    begin rw = 1; rd = 1; end
      S_BRANCH: begin a = 2'b01; op = 4'b0000; ps = 2'b01; pe = (opc == 6'b000100) ? z : !z; end
      S_IEX: begin
        a = 2'b01; b = 2'b10;
        if (opc == 6'b001100) begin op = 4'b1000; es = 1; end
        else if (opc == 6'b001101) begin op = 4'b1001; es = 1; end
      end
      S_IWB:    rw = 1;
      S_JUMP:   begin ps = 2'b10; pe = 1; end
      default:  ;
    endcase
    return {pe, io, mw, irw, rw, rd, m2r, a, b, es, ps, op, ill};
  endfunction

  // Called just after a rising edge with the DUT in FETCH.
  // zmode: 0/1 hold zero at that value, 2 = random zero every cycle.
  // stop_before: number of steps to run (0 = whole instruction).
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input int zmode, input int stop_before);
    step_t seq[$];
    int n;
    opcode = opc;
    funct  = fn;
    seq = {S_FETCH, S_DECODE};
    case (opc)
      6'b100011: seq = {seq, S_MEMADR, S_MEMRD, S_MEMWB};
      6'b101011: seq = {seq, S_MEMADR, S_MEMWR};
      6'b000100, 6'b000101: seq.push_back(S_BRANCH);
      6'b001000, 6'b001100, 6'b001101: seq = {seq, S_IEX, S_IWB};
      6'b000010: seq.push_back(S_JUMP);
      6'b000000: if (r_alu(fn) >= 0) seq = {seq, S_REX, S_RWB};
      default: ;
    endcase
    n = (stop_before > 0) ? stop_before : seq.size();
    for (int i = 0; i < n; i++) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      @(negedge clk);
      check($sformatf("op=%b fn=%b z=%0d step=%s", opc, fn, zero, seq[i].name()),
            32'(obs), 32'(exp_out(seq[i], opc, fn, zero)));
      if (i < n - 1 || stop_before == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  logic [5:0] legal_ops [8] = '{6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001100, 6'b001101, 6'b000010};
  logic [5:0] legal_fns [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b100110, 6'b000000, 6'b000011};

  initial begin
    logic [5:0] ro, rf;
    #2 reset = 1'b1;
    // Strobes stay low for the whole reset, whatever the inputs do.
    for (int i = 0; i < 3; i++) begin
      opcode = 6'($urandom);
      zero   = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_strobes", 32'(strobes), 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Directed instructions
    run_instr(6'b100011, 6'b000000, 2, 0);  // lw
    run_instr(6'b000000, 6'b000011, 2, 0);  // sra
    run_instr(6'b000000, 6'b100010, 2, 0);  // sub
    run_instr(6'b000100, 6'b000000, 1, 0);  // beq taken
    run_instr(6'b000100, 6'b000000, 0, 0);  // beq not taken
    run_instr(6'b000101, 6'b000000, 1, 0);  // bne not taken
    run_instr(6'b000101, 6'b000000, 0, 0);  // bne taken
    run_instr(6'b001101, 6'b000000, 2, 0);  // ori
    run_instr(6'b111111, 6'b000000, 2, 0);  // illegal opcode
    run_instr(6'b000000, 6'b000000, 2, 0);  // nop (sll)
    run_instr(6'b000000, 6'b111111, 2, 0);  // illegal funct
    run_instr(6'b101011, 6'b000000, 2, 0);  // sw
    run_instr(6'b000010, 6'b000000, 1, 0);  // j
    run_instr(6'b001000, 6'b000000, 2, 0);  // addi
    run_instr(6'b001100, 6'b000000, 2, 0);  // andi

    // Reset in the MEMWR cycle of sw: the write strobe must drop at once.
    run_instr(6'b101011, 6'b000000, 2, 4);
    #1 reset = 1'b1;
    #1 check("rst_memwr_mem_write", 32'(mem_write), 32'h0);
    check("rst_memwr_strobes", 32'(strobes), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_strobes", 32'(strobes), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr(6'b100011, 6'b000000, 2, 0);  // resumes from FETCH

    // Randomized instruction mix
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) < 4) begin
        ro = legal_ops[$urandom_range(0, 7)];
        rf = 6'($urandom);
      end else if ($urandom_range(0, 9) < 7) begin
        ro = 6'b000000;
        rf = ($urandom_range(0, 3) != 0) ? legal_fns[$urandom_range(0, 6)] : 6'($urandom);
      end else begin
        ro = 6'($urandom);
        rf = 6'($urandom);
      end
      run_instr(ro, rf, 2, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main controller that sequences the shared datapath (PC, IR, register file, memory, ALU) one instruction at a time.
- Decodes opcode/funct and drives every mux select, write enable and the 4-bit ALU operation select each cycle.
- Computes the branch-qualified PC enable from the ALU zero flag.
- Sits between the instruction register and the datapath; the only control source for the ALU.

Parameters:
- PC_INC, 4, constant chosen by alu_src_b = 2'b01; informational, fixed to the datapath constant.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  IR[31:26]
- funct  input  6  IR[5:0]
- zero  input  1  ALU zero flag (1 when ALU result is 0)
- pc_en  output  1  PC load enable = pc_write | (branch_eq & zero) | (branch_ne & ~zero)
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  instruction register load
- reg_write  output  1  register file write
- reg_dst  output  1  write register: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR
- alu_src_a  output  2  00 = PC, 01 = A, 10 = zero-extended shamt
- alu_src_b  output  2  00 = B, 01 = 4, 10 = ext(imm), 11 = signext(imm) << 2
- ext_sel  output  1  immediate extension: 0 = sign, 1 = zero
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_sel  output  4  ALU op: ADD = 0010, SUB = 0000, SLL = 0011, SRA = 0111, AND = 1000, OR = 1001, XOR = 1010
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct
- state_o  output  4  current state, for debug

Behaviour:
- Reset and output style
  - Moore FSM; every output except pc_en is a function of the state register only.
  - On reset assertion: state <= FETCH immediately.
  - While reset = 1, all write enables are forced 0: pc_en, mem_write, ir_write, reg_write. illegal = 0.
  - The first FETCH executes on the first rising edge after reset deasserts.
  - Reset mid-instruction abandons it; no partial register or memory write after reset asserts.
- Default outputs (every state unless overridden): all strobes 0, selects 0, alu_sel = ADD.
- States and outputs, with transitions:
  - FETCH: iord = 0, ir_write = 1, alu_src_a = 00, alu_src_b = 01, ADD, pc_src = 00, pc_write = 1. -> DECODE.
  - DECODE: alu_src_a = 00, alu_src_b = 11, ADD (branch target to ALUOut).
    - -> MEMADR: lw 100011, sw 101011.
    - -> RTYPE_EX: opcode 000000 with a legal funct.
    - -> BRANCH: beq 000100, bne 000101.
    - -> IMM_EX: addi 001000, andi 001100, ori 001101.
    - -> JUMP: j 000010.
    - -> FETCH with illegal = 1 for anything else.
  - MEMADR: alu_src_a = 01, alu_src_b = 10, ext_sel = 0, ADD. -> MEMRD (lw) or MEMWR (sw).
  - MEMRD: iord = 1. -> MEMWB.
  - MEMWB: reg_write = 1, reg_dst = 0, mem_to_reg = 1. -> FETCH.
  - MEMWR: iord = 1, mem_write = 1. -> FETCH.
  - RTYPE_EX: alu_src_b = 00.
    - alu_src_a = 10 for sll/sra, 01 otherwise.
    - Funct map: 100000 -> ADD, 100010 -> SUB, 100100 -> AND, 100101 -> OR, 100110 -> XOR, 000000 -> SLL, 000011 -> SRA.
    - -> RTYPE_WB.
  - RTYPE_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
  - BRANCH: alu_src_a = 01, alu_src_b = 00, SUB, pc_src = 01.
    - beq: branch_eq = 1. bne: branch_ne = 1.
    - -> FETCH.
  - IMM_EX: alu_src_a = 01, alu_src_b = 10.
    - addi: ADD, ext_sel = 0. andi: AND, ext_sel = 1. ori: OR, ext_sel = 1.
    - -> IMM_WB.
  - IMM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
  - JUMP: pc_src = 10, pc_write = 1. -> FETCH.
- Illegal funct (opcode 000000, funct not in the map) is detected in DECODE. illegal pulses, no writes occur, and the next state is FETCH.
- sll with rd = 0 (nop, word 0x00000000) is legal and executes normally.
- pc_en is combinational from state and zero; it may depend on zero only in BRANCH.
- Cycle counts: lw 5; sw, R-type, addi/andi/ori 4; beq, bne, j 3; illegal 2.
- Unused state encodings -> FETCH on the next edge with all strobes 0.

Test Plan:
- Reset held 3 cycles, then released -> strobes 0 during reset; first cycle is FETCH with ir_write = 1, pc_en = 1, alu_sel = 0010, alu_src_b = 01.
- lw (opcode 100011) -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; iord = 1 in MEMRD; reg_write = 1 with mem_to_reg = 1 only in MEMWB.
- R-type funct 000011 (sra) -> RTYPE_EX shows alu_sel = 0111 and alu_src_a = 10; next cycle reg_write = 1 with reg_dst = 1. Repeat with funct 100010 -> alu_sel = 0000, alu_src_a = 01.
- beq with zero = 1, then beq with zero = 0 -> pc_en = 1 / 0 in BRANCH. Same two cases for bne -> pc_en = 0 / 1. pc_src = 01 in all four.
- ori (001101) -> IMM_EX shows ext_sel = 1 and alu_sel = 1001. Opcode 111111 -> illegal = 1 for one cycle in DECODE, returns to FETCH, no write strobes.
- Reset asserted during MEMWR of sw -> mem_write drops in the same cycle; state = FETCH after release.
